// File: rtl/aes_pkg.sv
// Shared types and constants for the word-serial AES stream loader.
package aes_pkg;

  localparam int WORD_W    = 32;
  localparam int BLK_WORDS = 4;
  localparam int BLK_W     = WORD_W * BLK_WORDS;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_KEY,
    LOAD_DATA,
    WAIT,
    OUT
  } state_e;

endpackage

// File: rtl/aes_out_serializer.sv
// Holds the captured ciphertext block and streams it out MSB word first,
// stalling on m_ready.
module aes_out_serializer
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [BLK_W-1:0]  din,
  input  logic              m_ready,
  output logic              m_valid,
  output logic [WORD_W-1:0] m_data,
  output logic              m_last,
  output logic              done
);

  logic [BLK_W-1:0] result_q, result_d;
  logic [1:0]       ocnt_q, ocnt_d;
  logic             valid_q, valid_d;
  logic             take;

  assign take = valid_q & m_ready;

  // Next-state for result register, word index and valid flag.
  always_comb begin
    result_d = result_q;
    ocnt_d   = ocnt_q;
    valid_d  = valid_q;
    if (load) begin
      result_d = din;
      ocnt_d   = 2'd0;
      valid_d  = 1'b1;
    end else if (take) begin
      if (ocnt_q == 2'd3) begin
        valid_d = 1'b0;
      end else begin
        ocnt_d = ocnt_q + 2'd1;
      end
    end
  end

  // Output-side state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      ocnt_q   <= 2'd0;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      ocnt_q   <= ocnt_d;
      valid_q  <= valid_d;
    end
  end

  // Select the current word; held stable because ocnt only moves on a take.
  always_comb begin
    m_data = '0;
    for (int k = 0; k < BLK_WORDS; k++) begin
      if (ocnt_q == 2'(k)) m_data = result_q[BLK_W-1-WORD_W*k -: WORD_W];
    end
  end

  assign m_valid = valid_q;
  assign m_last  = valid_q && (ocnt_q == 2'd3);
  assign done    = take && m_last;

endmodule

// File: rtl/aes_stream_loader.sv
// Word-serial front/back end for a combinational AES core: loads key and
// plaintext, holds them for a multicycle settle window, then serialises
// the captured ciphertext.
module aes_stream_loader
  import aes_pkg::*;
#(
  parameter int NK            = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [WORD_W-1:0]    s_data,
  input  logic                 s_key,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [WORD_W-1:0]    m_data,
  output logic                 m_last,
  output logic [NK*WORD_W-1:0] core_key,
  output logic [BLK_W-1:0]     core_datain,
  input  logic [BLK_W-1:0]     core_dataout,
  output logic                 busy,
  output logic                 err_nokey
);

  localparam int         KEY_W      = NK * WORD_W;
  localparam logic [2:0] WLAST_KEY  = 3'(NK - 1);
  localparam logic [2:0] WLAST_DATA = 3'(BLK_WORDS - 1);
  localparam logic [7:0] SCNT_INIT  = 8'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [2:0]       wcnt_q, wcnt_d;
  logic [7:0]       scnt_q, scnt_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [BLK_W-1:0] data_q, data_d;
  logic             key_loaded_q, key_loaded_d;
  logic             s_ready_q, s_ready_d;
  logic             err_nokey_q, err_nokey_d;
  logic             s_xfer;
  logic             capture;
  logic             ser_done;

  assign s_xfer = s_valid & s_ready_q;

  // Loader FSM: next state, word writes into key/data, counters.
  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    scnt_d       = scnt_q;
    key_d        = key_q;
    data_d       = data_q;
    key_loaded_d = key_loaded_q;
    err_nokey_d  = 1'b0;
    capture      = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_xfer) begin
          if (s_key) begin
            key_d[KEY_W-1 -: WORD_W] = s_data;
            if (NK > 1) begin
              state_d = LOAD_KEY;
              wcnt_d  = 3'd1;
            end else begin
              key_loaded_d = 1'b1;
              state_d      = LOAD_DATA;
              wcnt_d       = 3'd0;
            end
          end else begin
            data_d[BLK_W-1 -: WORD_W] = s_data;
            state_d     = LOAD_DATA;
            wcnt_d      = 3'd1;
            err_nokey_d = !key_loaded_q;
          end
        end
      end
      LOAD_KEY: begin
        if (s_xfer) begin
          for (int k = 0; k < NK; k++) begin
            if (wcnt_q == 3'(k)) key_d[KEY_W-1-WORD_W*k -: WORD_W] = s_data;
          end
          if (wcnt_q == WLAST_KEY) begin
            key_loaded_d = 1'b1;
            state_d      = LOAD_DATA;
            wcnt_d       = 3'd0;
          end else begin
            wcnt_d = wcnt_q + 3'd1;
          end
        end
      end
      LOAD_DATA: begin
        if (s_xfer) begin
          for (int k = 0; k < BLK_WORDS; k++) begin
            if (wcnt_q == 3'(k)) data_d[BLK_W-1-WORD_W*k -: WORD_W] = s_data;
          end
          if (wcnt_q == WLAST_DATA) begin
            state_d = WAIT;
            scnt_d  = SCNT_INIT;
          end else begin
            wcnt_d = wcnt_q + 3'd1;
          end
        end
      end
      WAIT: begin
        // Core inputs are frozen here; the core result is taken once the
        // settle window has elapsed.
        if (scnt_q == 8'd0) begin
          capture = 1'b1;
          state_d = OUT;
        end else begin
          scnt_d = scnt_q - 8'd1;
        end
      end
      OUT: begin
        if (ser_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    s_ready_d = (state_d == IDLE) || (state_d == LOAD_KEY) || (state_d == LOAD_DATA);
  end

  // Loader state registers; reset discards any partial job and the key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wcnt_q       <= 3'd0;
      scnt_q       <= 8'd0;
      key_q        <= '0;
      data_q       <= '0;
      key_loaded_q <= 1'b0;
      s_ready_q    <= 1'b0;
      err_nokey_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      scnt_q       <= scnt_d;
      key_q        <= key_d;
      data_q       <= data_d;
      key_loaded_q <= key_loaded_d;
      s_ready_q    <= s_ready_d;
      err_nokey_q  <= err_nokey_d;
    end
  end

  aes_out_serializer u_ser (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (capture),
    .din     (core_dataout),
    .m_ready (m_ready),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_last  (m_last),
    .done    (ser_done)
  );

  assign s_ready     = s_ready_q;
  assign busy        = (state_q != IDLE);
  assign err_nokey   = err_nokey_q;
  assign core_key    = key_q;
  assign core_datain = data_q;

endmodule

// File: tb/tb_aes_stream_loader.sv
// Directed bench for aes_stream_loader with behavioural AES cores (NK=8, NK=4).
module tb_aes_stream_loader;

  localparam int S8 = 4;
  localparam int S4 = 1;

  logic clk = 1'b0;
  logic rst_n;
  logic s_valid, s_key, m_ready, sel4;
  logic [31:0] s_data;
  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  logic         s_ready8, m_valid8, m_last8, busy8, err8;
  logic [31:0]  m_data8;
  logic [255:0] core_key8;
  logic [127:0] core_din8, core_out8;
  logic         s_ready4, m_valid4, m_last4, busy4, err4;
  logic [31:0]  m_data4;
  logic [127:0] core_key4, core_din4, core_out4;

  logic        s_ready_m, m_valid_m, m_last_m, busy_m, err_m;
  logic [31:0] m_data_m;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- AES reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r, p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] aes_enc(input logic [255:0] key, input logic [127:0] pt,
                                           input int nk);
    logic [31:0]  w [60];
    logic [7:0]   st [16];
    logic [7:0]   tmp [16];
    logic [31:0]  t;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] rk, res;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[32*(nk-1-i) +: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    rk = {w[0], w[1], w[2], w[3]};
    for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ rk[127-8*i -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) tmp[i] = sbox(st[i]);
      for (int rr = 0; rr < 4; rr++)
        for (int c = 0; c < 4; c++) st[rr+4*c] = tmp[rr+4*((c+rr)%4)];
      if (r != nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
          st[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          st[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          st[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          st[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      rk = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ rk[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
    return res;
  endfunction

  assign core_out8 = aes_enc(core_key8, core_din8, 8);
  assign core_out4 = aes_enc(256'(core_key4), core_din4, 4);

  // ---------------- DUTs ----------------
  aes_stream_loader #(.NK(8), .SETTLE_CYCLES(S8)) u8 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid & ~sel4), .s_ready(s_ready8),
    .s_data(s_data), .s_key(s_key), .m_valid(m_valid8), .m_ready(m_ready),
    .m_data(m_data8), .m_last(m_last8), .core_key(core_key8), .core_datain(core_din8),
    .core_dataout(core_out8), .busy(busy8), .err_nokey(err8)
  );

  aes_stream_loader #(.NK(4), .SETTLE_CYCLES(S4)) u4 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid & sel4), .s_ready(s_ready4),
    .s_data(s_data), .s_key(s_key), .m_valid(m_valid4), .m_ready(m_ready),
    .m_data(m_data4), .m_last(m_last4), .core_key(core_key4), .core_datain(core_din4),
    .core_dataout(core_out4), .busy(busy4), .err_nokey(err4)
  );

  assign s_ready_m = sel4 ? s_ready4 : s_ready8;
  assign m_valid_m = sel4 ? m_valid4 : m_valid8;
  assign m_last_m  = sel4 ? m_last4  : m_last8;
  assign busy_m    = sel4 ? busy4    : busy8;
  assign err_m     = sel4 ? err4     : err8;
  assign m_data_m  = sel4 ? m_data4  : m_data8;

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word and hold it until accepted; t = cycle of the transfer.
  task automatic send1(input logic [31:0] d, input logic k, output int t);
    bit rdy;
    int guard;
    s_valid = 1'b1;
    s_data  = d;
    s_key   = k;
    guard   = 0;
    do begin
      rdy = s_ready_m;
      t   = cyc;
      tick();
      guard++;
    end while (!rdy && guard < 50);
    if (!rdy) check("s_ready_timeout", 0, 1);
  endtask

  task automatic run_job(input bit use4, input bit with_key, input logic [255:0] key,
                         input int nk, input logic [127:0] pt, input logic [127:0] exp_ct,
                         input bit bp, input bit exp_err, input string tag);
    int t, t3, guard, got, settle;
    bit stall;
    logic [32:0] held;
    sel4   = use4;
    settle = use4 ? S4 : S8;
    if (with_key) begin
      for (int i = 0; i < nk; i++) begin
        send1(key[32*(nk-1-i) +: 32], (i == 0), t);
        if (i == 0) check({tag, "_err_keyjob"}, err_m, 0);
      end
    end
    for (int d = 0; d < 4; d++) begin
      send1(pt[127-32*d -: 32], 1'b0, t);
      if (!with_key && d == 0) check({tag, "_err_pulse"}, err_m, exp_err);
      if (!with_key && d == 1) check({tag, "_err_end"}, err_m, 0);
    end
    t3 = t;
    s_valid = 1'b0;
    check({tag, "_sready_wait"}, s_ready_m, 0);
    check({tag, "_busy_wait"}, busy_m, 1);
    guard = 0;
    while (!m_valid_m && guard < 300) begin
      tick();
      guard++;
    end
    check({tag, "_latency"}, 256'(cyc - t3), 256'(settle + 1));
    got = 0;
    stall = 1'b0;
    held = '0;
    guard = 0;
    while (got < 4 && guard < 200) begin
      m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall) check({tag, "_hold"}, {m_valid_m, m_last_m, m_data_m}, {1'b1, held});
      check({tag, "_sready_out"}, s_ready_m, 0);
      if (m_valid_m && m_ready) begin
        check({tag, "_word"}, m_data_m, exp_ct[127-32*got -: 32]);
        check({tag, "_last"}, m_last_m, (got == 3));
        got++;
      end
      stall = m_valid_m && !m_ready;
      held  = {m_last_m, m_data_m};
      tick();
      guard++;
    end
    if (got < 4) check({tag, "_out_timeout"}, 256'(got), 4);
    m_ready = 1'b0;
    check({tag, "_sready_after"}, s_ready_m, 1);
    check({tag, "_busy_after"}, busy_m, 0);
    check({tag, "_mvalid_after"}, m_valid_m, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, s_ready8, 0);
    check({tag, "_m_valid"}, m_valid8, 0);
    check({tag, "_m_last"}, m_last8, 0);
    check({tag, "_busy"}, busy8, 0);
    check({tag, "_err"}, err8, 0);
    check({tag, "_m_data"}, m_data8, 0);
    check({tag, "_core_key"}, core_key8, 0);
    check({tag, "_core_din"}, core_din8, 0);
  endtask

  // ---------------- directed sequence ----------------
  localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEY128 = 256'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  initial begin
    logic [127:0] ct_zero;
    int t;
    rst_n = 1'b1; s_valid = 1'b0; s_data = '0; s_key = 1'b0; m_ready = 1'b0; sel4 = 1'b0;
    ct_zero = aes_enc(256'h0, PT, 8);
    #2 rst_n = 1'b0;
    repeat (2) tick();
    check_reset_outputs("rst0");
    check("rst0_u4_ready", {s_ready4, m_valid4, busy4, err4}, 0);
    check("rst0_u4_key", core_key4, 0);
    rst_n = 1'b1;
    tick();
    check("rst0_ready_rise", s_ready8, 1);

    // data-only job with no key since reset: zero key, err pulse
    run_job(0, 0, 256'h0, 8, PT, ct_zero, 0, 1, "nokey");
    // full AES-256 key job
    run_job(0, 1, KEY256, 8, PT, CT256, 0, 0, "k256");
    check("k256_core_key", core_key8, KEY256);
    // key reuse under backpressure
    run_job(0, 0, 256'h0, 8, PT, CT256, 1, 0, "reuse");
    // AES-128 instance, shortest settle, backpressure
    run_job(1, 1, KEY128, 4, PT, CT128, 1, 0, "k128");
    check("k128_core_key", core_key4, KEY128[127:0]);

    // reset while in WAIT
    sel4 = 1'b0;
    for (int i = 0; i < 8; i++) send1(KEY256[32*(7-i) +: 32], (i == 0), t);
    for (int d = 0; d < 4; d++) send1(PT[127-32*d -: 32], 1'b0, t);
    s_valid = 1'b0;
    tick();
    check("wait_busy", busy8, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_wait");
    tick();
    rst_n = 1'b1;
    tick();
    run_job(0, 0, 256'h0, 8, PT, ct_zero, 0, 1, "post_wait");

    // reset in the middle of a key load
    for (int i = 0; i < 3; i++) send1(KEY256[32*(7-i) +: 32], (i == 0), t);
    s_valid = 1'b0;
    check("midkey_busy", busy8, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_key");
    tick();
    rst_n = 1'b1;
    tick();
    run_job(0, 0, 256'h0, 8, PT, ct_zero, 1, 1, "post_key");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes_stream_loader.md
Name: aes_stream_loader

Overview:
Word-serial front/back end for the combinational AES encryption core.
- Collects a cipher key (NK words) and a 128-bit plaintext block over a 32-bit valid/ready stream, then holds both stable on the core inputs.
- Waits a fixed number of settle cycles (multicycle path through the core), then registers the core output.
- Returns the ciphertext as four 32-bit words on an output valid/ready stream.

Parameters:
NK, 8, key length in 32-bit words (4, 6 or 8); must match the core instance.
SETTLE_CYCLES, 4, cycles the core inputs are held before capture; legal range 1..255.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
s_valid  in  1  input word valid
s_ready  out  1  input word ready
s_data  in  32  input word
s_key  in  1  sampled only on first word of a job: 1 = job starts with NK key words
m_valid  out  1  output word valid
m_ready  in  1  output word ready
m_data  out  32  ciphertext word
m_last  out  1  high with 4th output word
core_key  out  NK*32  to core key input, registered
core_datain  out  128  to core data input, registered
core_dataout  in  128  from core output
busy  out  1  high in any state except IDLE
err_nokey  out  1  one-cycle pulse: data-only job started with no key loaded since reset

Behaviour:
- Reset (async, rst_n=0) clears the following to 0:
  - state returns to IDLE;
  - s_ready, m_valid, m_last, busy, err_nokey, m_data are 0;
  - core_key, core_datain, the result register and the key_loaded flag are 0.
- Reset mid-job aborts the job; the partial key/data is discarded.
- Handshake: a transfer occurs on a rising edge with valid and ready both high.
  - m_data and m_last stay stable while m_valid is high and m_ready is low.
- Word order is MSB first.
  - Key word k (0..NK-1) fills core_key[NK*32-1-32k -: 32].
  - Data word d (0..3) fills core_datain[127-32d -: 32].
  - Output word d comes from result[127-32d -: 32].
- States:
  - IDLE: s_ready=1.
    - On a transfer with s_key=1: word is key word 0; go to LOAD_KEY (if NK>1), wcnt=1.
    - On a transfer with s_key=0: word is data word 0; go to LOAD_DATA, wcnt=1.
    - If key_loaded=0 when a data-only job starts, pulse err_nokey and process with the current (zero) key.
  - LOAD_KEY: s_ready=1; s_key ignored.
    - Each transfer writes the next key word.
    - After word NK-1, set key_loaded=1, go to LOAD_DATA, wcnt=0.
  - LOAD_DATA: s_ready=1; each transfer writes the next data word.
    - The transfer of data word 3 (cycle T) enters WAIT with scnt=SETTLE_CYCLES-1.
  - WAIT: s_ready=0; core_key/core_datain unchanged.
    - Decrement scnt each cycle.
    - In the cycle scnt==0, capture core_dataout into the result register and go to OUT with ocnt=0.
    - Hence capture occurs at the edge ending cycle T+SETTLE_CYCLES, and m_valid first rises in cycle T+SETTLE_CYCLES+1.
  - OUT: s_ready=0; m_valid=1, m_data=result word ocnt, m_last=(ocnt==3).
    - Each output transfer increments ocnt.
    - The transfer with m_last returns to IDLE; s_ready is 1 in the next cycle.
- Key persistence: the key register keeps its value across jobs; a data-only job reuses it.
- A key job interrupted by reset leaves key_loaded=0.
- No overlap: the next job is not accepted until the last output word is taken.
  - Throughput is one block per (NK or 0) + 4 + SETTLE_CYCLES + 4 cycles minimum.
- Counters: wcnt 3 bits, scnt 8 bits, ocnt 2 bits. None wraps except by explicit reload on state entry.

Decomposition:
- Shared package aes_pkg holds:
  - state enum {IDLE, LOAD_KEY, LOAD_DATA, WAIT, OUT};
  - constants WORD_W=32, BLK_WORDS=4.
- One natural sub-module, aes_out_serializer: holds the 128-bit result register and the 2-bit word index, and drives m_valid/m_data/m_last with valid/ready stalling.
- The loader FSM lives in the top.

Test Plan:
- The bench instantiates the real core with matching NK.
- NK=8, s_key=1 job:
  - Stimulus: key 00010203…1c1d1e1f (8 words), then data 00112233, 44556677, 8899aabb, ccddeeff; m_ready held 1.
  - Response: m_data 8ea2b7ca, 516745bf, eafc4990, 4b496089; m_last on the 4th word; first m_valid exactly SETTLE_CYCLES+1 cycles after data word 3.
- NK=4:
  - Stimulus: key 00010203…0c0d0e0f, then the same plaintext.
  - Response: 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a.
- Key reuse: after the NK=8 job, a data-only job (s_key=0) with the same plaintext -> identical ciphertext; err_nokey stays 0.
- Backpressure and ready behaviour:
  - Stimulus: m_ready toggled 0/1 randomly during OUT.
  - Response: each word is held stable until taken; s_ready stays 0 until the m_last transfer, then 1 the next cycle.
- No-key error: data-only job directly after reset -> err_nokey pulses for one cycle on word 0; output equals AES of the plaintext under an all-zero key.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 in WAIT and again mid-LOAD_KEY.
  - Response: all outputs return to 0 immediately; key_loaded is cleared; a following data-only job raises err_nokey.
